hazard_stall_ctrl: RTL and testbench

- Parametrised load-use hazard controller for the in-order pipeline.
- Compares decode-stage source registers against destination registers of loads in flight across NUM_STAGES downstream stages.
- Computes the required stall depth and holds it in a registered down-counter, so stalls span multiple cycles without relying on combinational feedback.
- Drives PC/IF-ID hold and ID-EX bubble insertion. Supports external hold (memory wait) and flush (taken branch/jump).

---
 rtl/hazard_stall_ctrl.sv | 73 +++++++
 tb/tb_hazard_stall_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard controller: compares decode sources against in-flight load
// destinations and holds the required stall depth in a registered down-counter.
// Optional build macro: HD_ZERO_REG_EXEMPT_EN (r0 reads never match).
module hazard_stall_ctrl #(
  parameter int REG_AW       = 4,
  parameter int NUM_STAGES   = 2,
  parameter int LOAD_LATENCY = 3,
  parameter int CNT_W        = $clog2(LOAD_LATENCY + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         d_valid,
  input  logic [REG_AW-1:0]            d_raddr1,
  input  logic [REG_AW-1:0]            d_raddr2,
  input  logic                         d_use1,
  input  logic                         d_use2,
  input  logic [NUM_STAGES-1:0]        s_valid,
  input  logic [NUM_STAGES-1:0]        s_isload,
  input  logic [NUM_STAGES*REG_AW-1:0] s_wreg,
  input  logic                         hold,
  input  logic                         flush,
  output logic                         pc_stall,
  output logic                         ifid_stall,
  output logic                         idex_bubble,
  output logic [CNT_W-1:0]             stall_cnt
);

  logic                  src1_ok, src2_ok;
  logic [NUM_STAGES-1:0] match;
  logic [CNT_W-1:0]      need, eff;
  logic                  stall;

`ifdef HD_ZERO_REG_EXEMPT_EN
  // r0 is hard-wired zero, so a read of it can never depend on a load
  assign src1_ok = d_use1 & (d_raddr1 != '0);
  assign src2_ok = d_use2 & (d_raddr2 != '0);
`else
  assign src1_ok = d_use1;
  assign src2_ok = d_use2;
`endif

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    logic [REG_AW-1:0] wreg;
    assign wreg     = s_wreg[g*REG_AW +: REG_AW];
    assign match[g] = s_valid[g] & s_isload[g] & d_valid &
                      ((src1_ok & (d_raddr1 == wreg)) | (src2_ok & (d_raddr2 == wreg)));
  end

  // Deeper stages are closer to writeback, so they need fewer stall cycles
  always_comb begin
    need = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (match[i] && (i < LOAD_LATENCY) && (CNT_W'(LOAD_LATENCY - i) > need))
        need = CNT_W'(LOAD_LATENCY - i);
    end
  end

  assign eff   = (stall_cnt > need) ? stall_cnt : need;
  assign stall = (eff != '0) & ~flush & ~rst;

  assign pc_stall    = stall;
  assign ifid_stall  = stall;
  assign idex_bubble = stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               stall_cnt <= '0;
    else if (flush)        stall_cnt <= '0;
    else if (hold)         stall_cnt <= stall_cnt;
    else if (eff != '0)    stall_cnt <= eff - CNT_W'(1);
    else                   stall_cnt <= '0;
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random traffic on two
// configurations (2 stages/latency 3 and 3 stages/latency 4) against a reference model.
module tb_hazard_stall_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dv = 1'b0, u1 = 1'b0, u2 = 1'b0, hold = 1'b0, flush = 1'b0;
  logic [3:0]  a1 = '0, a2 = '0;
  logic [1:0]  sv = '0, sl = '0;
  logic [7:0]  sw = '0;
  logic [2:0]  bsv = '0, bsl = '0;
  logic [11:0] bsw = '0;
  logic        pc_a, ifid_a, idex_a, pc_b, ifid_b, idex_b;
  logic [1:0]  cnt_a;
  logic [2:0]  cnt_b;

  int tests = 0;
  int fails = 0;
  int ma = 0, mb = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.REG_AW(4), .NUM_STAGES(2), .LOAD_LATENCY(3)) dut_a (
    .clk(clk), .rst(rst), .d_valid(dv), .d_raddr1(a1), .d_raddr2(a2),
    .d_use1(u1), .d_use2(u2), .s_valid(sv), .s_isload(sl), .s_wreg(sw),
    .hold(hold), .flush(flush), .pc_stall(pc_a), .ifid_stall(ifid_a),
    .idex_bubble(idex_a), .stall_cnt(cnt_a));

  hazard_stall_ctrl #(.REG_AW(4), .NUM_STAGES(3), .LOAD_LATENCY(4)) dut_b (
    .clk(clk), .rst(rst), .d_valid(dv), .d_raddr1(a1), .d_raddr2(a2),
    .d_use1(u1), .d_use2(u2), .s_valid(bsv), .s_isload(bsl), .s_wreg(bsw),
    .hold(hold), .flush(flush), .pc_stall(pc_b), .ifid_stall(ifid_b),
    .idex_bubble(idex_b), .stall_cnt(cnt_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Required stall cycles: each matching load needs latency minus its depth.
  function automatic int need_f(int ns, int ll, logic [3:0] v, logic [3:0] ld, logic [15:0] w);
    int n = 0;
    for (int i = 0; i < ns; i++) begin
      int dst = int'(w[i*4 +: 4]);
      bit r1  = u1 && (int'(a1) == dst);
      bit r2  = u2 && (int'(a2) == dst);
`ifdef HD_ZERO_REG_EXEMPT_EN
      if (a1 == 4'd0) r1 = 0;
      if (a2 == 4'd0) r2 = 0;
`endif
      if (dv && v[i] && ld[i] && (r1 || r2) && i < ll && (ll - i) > n) n = ll - i;
    end
    return n;
  endfunction

  // One clock: check combinational outputs, then the counter after the edge.
  task automatic cycle();
    int ea, eb;
    bit xa, xb;
    #1;
    ea = need_f(2, 3, {2'b0, sv}, {2'b0, sl}, {8'b0, sw});
    eb = need_f(3, 4, {1'b0, bsv}, {1'b0, bsl}, {4'b0, bsw});
    if (ma > ea) ea = ma;
    if (mb > eb) eb = mb;
    xa = (ea != 0) && !flush;
    xb = (eb != 0) && !flush;
    chk("a_pc_stall", pc_a, xa);
    chk("a_ifid_stall", ifid_a, xa);
    chk("a_idex_bubble", idex_a, xa);
    chk("b_pc_stall", pc_b, xb);
    chk("b_idex_bubble", idex_b, xb);
    @(posedge clk);
    if (flush) begin ma = 0; mb = 0; end
    else if (!hold) begin
      ma = (ea > 0) ? ea - 1 : 0;
      mb = (eb > 0) ? eb - 1 : 0;
    end
    #1;
    chk("a_stall_cnt", cnt_a, ma);
    chk("b_stall_cnt", cnt_b, mb);
  endtask

  task automatic clr();
    dv = 0; u1 = 0; u2 = 0; a1 = 0; a2 = 0; hold = 0; flush = 0;
    sv = 0; sl = 0; sw = 0; bsv = 0; bsl = 0; bsw = 0;
  endtask

  // Load r5 in EX of config A with decode reading r5 on src1.
  task automatic ex_hazard();
    dv = 1; a1 = 4'd5; u1 = 1; sv = 2'b01; sl = 2'b01; sw = 8'h05;
  endtask

  initial begin
    // reset state, with a live hazard on the inputs
    ex_hazard();
    #2;
    chk("rst_pc_stall", pc_a, 0);
    chk("rst_cnt", cnt_a, 0);
    @(posedge clk); #1;
    chk("rst_cnt_after_edge", cnt_a, 0);
    rst = 0;
    clr();
    cycle();

    // EX hazard: 3 stall cycles, counter 2,1,0
    ex_hazard();
    cycle();
    chk("ex_cnt_2", cnt_a, 2);
    sv = 0;
    cycle();
    chk("ex_cnt_1", cnt_a, 1);
    cycle();
    chk("ex_cnt_0", cnt_a, 0);
    cycle();
    chk("ex_released", pc_a, 0);

    // MEM hazard on src2: 2 cycles; then with d_use2=0: none
    clr();
    dv = 1; a2 = 4'd5; u2 = 1; sv = 2'b10; sl = 2'b10; sw = 8'h50;
    cycle();
    chk("mem_cnt_1", cnt_a, 1);
    sv = 0;
    cycle();
    chk("mem_cnt_0", cnt_a, 0);
    cycle();
    sv = 2'b10; u2 = 0;
    cycle();
    chk("mem_nouse_cnt", cnt_a, 0);

    // hold freezes a stall at 2 and keeps it visible
    clr(); ex_hazard();
    cycle();
    sv = 0; hold = 1;
    repeat (4) cycle();
    chk("hold_cnt", cnt_a, 2);
    chk("hold_visible", pc_a, 1);
    hold = 0;
    cycle(); cycle();
    chk("hold_release_cnt", cnt_a, 0);
    cycle();

    // flush with a concurrent new hazard
    clr(); ex_hazard();
    cycle();
    flush = 1;
    #1;
    chk("flush_out_low", pc_a, 0);
    cycle();
    chk("flush_cnt", cnt_a, 0);
    flush = 0; sv = 0;
    cycle();

    // async reset mid-stall at stall_cnt=1
    clr(); ex_hazard();
    cycle();
    sv = 0;
    cycle();
    chk("pre_rst_cnt", cnt_a, 1);
    ex_hazard();
    #3; rst = 1; #1;
    chk("async_rst_cnt", cnt_a, 0);
    chk("async_rst_pc", pc_a, 0);
    chk("async_rst_bubble", idex_a, 0);
    ma = 0; mb = 0;
    @(posedge clk); #1;
    chk("rst_held_cnt", cnt_a, 0);
    rst = 0;
    clr();
    cycle();

    // load to r0 in EX, decode reads r0
    dv = 1; a1 = 4'd0; u1 = 1; sv = 2'b01; sl = 2'b01; sw = 8'h00;
    cycle();
`ifdef HD_ZERO_REG_EXEMPT_EN
    chk("r0_cnt", cnt_a, 0);
`else
    chk("r0_cnt", cnt_a, 2);
`endif
    sv = 0;
    cycle(); cycle(); cycle();

    // config B: hazard in stage 2 -> 2-cycle stall
    clr();
    dv = 1; a1 = 4'd7; u1 = 1; bsv = 3'b100; bsl = 3'b100; bsw = 12'h700;
    cycle();
    chk("b_stage2_cnt_1", cnt_b, 1);
    bsv = 0;
    cycle();
    chk("b_stage2_cnt_0", cnt_b, 0);
    cycle();

    // random traffic
    for (int k = 0; k < 400; k++) begin
      dv    = ($urandom_range(0, 7) != 0);
      a1    = 4'($urandom_range(0, 3));
      a2    = 4'($urandom_range(0, 3));
      u1    = 1'($urandom);
      u2    = 1'($urandom);
      sv    = 2'($urandom);
      sl    = 2'($urandom);
      sw    = {2'b0, 2'($urandom), 2'b0, 2'($urandom)};
      bsv   = 3'($urandom);
      bsl   = 3'($urandom);
      bsw   = {2'b0, 2'($urandom), 2'b0, 2'($urandom), 2'b0, 2'($urandom)};
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
